ahb_master_arbiter: RTL and testbench



---
 rtl/ahb_master_arbiter_if.sv | 38 +++
 rtl/ahb_master_arbiter.sv | 127 ++++++++++++
 tb/tb_ahb_master_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_master_arbiter_if.sv
// ahb_master_arbiter_if: request/grant bundle between AHB masters and the
// arbiter. `ARB_HMASTLOCK_EN adds the per-master i_hmastlock lines.
interface ahb_master_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int MW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]   i_hbusreq;
  logic [2*NUM_MASTERS-1:0] i_htrans;
  logic                     i_hready;
`ifdef ARB_HMASTLOCK_EN
  logic [NUM_MASTERS-1:0]   i_hmastlock;
`endif
  logic [NUM_MASTERS-1:0]   o_hgrant;
  logic [MW-1:0]            o_hmaster;
  logic [MW-1:0]            o_hmaster_dp;
  logic                     o_quantum_exp;

`ifdef ARB_HMASTLOCK_EN
  modport master (
    output i_hbusreq, i_htrans, i_hready, i_hmastlock,
    input  o_hgrant, o_hmaster, o_hmaster_dp, o_quantum_exp
  );
  modport slave (
    input  i_hbusreq, i_htrans, i_hready, i_hmastlock,
    output o_hgrant, o_hmaster, o_hmaster_dp, o_quantum_exp
  );
`else
  modport master (
    output i_hbusreq, i_htrans, i_hready,
    input  o_hgrant, o_hmaster, o_hmaster_dp, o_quantum_exp
  );
  modport slave (
    input  i_hbusreq, i_htrans, i_hready,
    output o_hgrant, o_hmaster, o_hmaster_dp, o_quantum_exp
  );
`endif
endinterface

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: round-robin AHB arbiter with beat quantum and parking.
// Ports: i_clk, i_rst (sync, high), bus (slave modport). Macro ARB_HMASTLOCK_EN.
module ahb_master_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MAX_BEATS      = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input logic                i_clk,
  input logic                i_rst,
  ahb_master_arbiter_if.slave bus
);
  localparam int MW = $clog2(NUM_MASTERS);
  localparam int CW = 8;
  localparam logic [MW-1:0] DEF  = MW'(DEFAULT_MASTER);
  localparam logic [CW-1:0] MAXB = CW'(MAX_BEATS);
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  typedef enum logic {PARK = 1'b0, OWN = 1'b1} state_t;

  state_t state, state_n;
  logic [NUM_MASTERS-1:0] hgrant, hgrant_n;
  logic [MW-1:0] hmaster, hmaster_n;
  logic [MW-1:0] hmaster_dp;
  logic [MW-1:0] rr_ptr, rr_n;
  logic [CW-1:0] beat_cnt, beat_n;
  logic          qexp, qexp_n;

  logic [1:0]    own_tr;
  logic          own_req, others, lock;
  logic          cond_a, cond_b, cond_c;
  logic          rearb, excl_own;
  logic          win_found;
  logic [MW-1:0] win, cand;

  assign own_tr  = bus.i_htrans[{hmaster, 1'b0} +: 2];
  assign own_req = bus.i_hbusreq[hmaster];
  // hgrant is the owner's one-hot, so masking with it leaves the rivals
  assign others  = |(bus.i_hbusreq & ~hgrant);

`ifdef ARB_HMASTLOCK_EN
  assign lock = (state == OWN) && bus.i_hmastlock[hmaster];
`else
  assign lock = 1'b0;
`endif

  assign cond_a = (state == PARK) && (|bus.i_hbusreq);
  assign cond_b = (state == OWN) && !own_req && !lock;
  // never hand over in the middle of a SEQ/BUSY burst
  assign cond_c = (state == OWN) && (beat_cnt == MAXB) && others &&
                  ((own_tr == T_IDLE) || (own_tr == T_NONSEQ)) && !lock;
  assign rearb    = bus.i_hready && (cond_a || cond_b || cond_c);
  // owner steps aside only for a pure quantum expiry
  assign excl_own = cond_c && !cond_b;

  always_comb begin
    win_found = 1'b0;
    win       = hmaster;
    cand      = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = MW'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (!win_found && bus.i_hbusreq[cand] &&
          !(excl_own && (cand == hmaster))) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    if (rearb) begin
      state_n = win_found ? OWN : PARK;
    end
  end

  always_comb begin
    hgrant_n  = hgrant;
    hmaster_n = hmaster;
    rr_n      = rr_ptr;
    qexp_n    = 1'b0;
    if (rearb) begin
      if (win_found) begin
        hmaster_n = win;
        hgrant_n  = NUM_MASTERS'(1) << win;
        rr_n      = win;
        qexp_n    = excl_own;
      end else begin
        hmaster_n = DEF;
        hgrant_n  = NUM_MASTERS'(1) << DEF;
      end
    end
    beat_n = beat_cnt;
    if (hmaster_n != hmaster) begin
      beat_n = '0;
    end else if (bus.i_hready && own_tr[1] && (beat_cnt < MAXB)) begin
      beat_n = beat_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= PARK;
      hgrant     <= NUM_MASTERS'(1) << DEF;
      hmaster    <= DEF;
      hmaster_dp <= DEF;
      rr_ptr     <= DEF;
      beat_cnt   <= '0;
      qexp       <= 1'b0;
    end else begin
      state    <= state_n;
      hgrant   <= hgrant_n;
      hmaster  <= hmaster_n;
      rr_ptr   <= rr_n;
      beat_cnt <= beat_n;
      qexp     <= qexp_n;
      if (bus.i_hready) begin
        hmaster_dp <= hmaster;
      end
    end
  end

  assign bus.o_hgrant      = hgrant;
  assign bus.o_hmaster     = hmaster;
  assign bus.o_hmaster_dp  = hmaster_dp;
  assign bus.o_quantum_exp = qexp;
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb_ahb_master_arbiter: directed stimulus, per-cycle reference model
// comparison plus hand-computed literal checks.
module tb_ahb_master_arbiter;
  localparam int N    = 4;
  localparam int MAXB = 4;
  localparam int DEFM = 0;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ahb_master_arbiter_if #(.NUM_MASTERS(N)) bus();

  ahb_master_arbiter #(
    .NUM_MASTERS(N),
    .MAX_BEATS(MAXB),
    .DEFAULT_MASTER(DEFM)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: owner index, parked flag, beats, last real owner
  int m_owner, m_rr, m_beats, m_dp;
  bit m_park, m_qexp, m_valid;

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = DEFM;
      m_rr    = DEFM;
      m_dp    = DEFM;
      m_beats = 0;
      m_park  = 1'b1;
      m_qexp  = 1'b0;
      m_valid = 1'b1;
    end else if (!bus.i_hready) begin
      m_qexp = 1'b0;
    end else begin : upd
      int tr, nxt, m, nreq;
      bit a, b, c, pick;
      tr   = (bus.i_htrans >> (2 * m_owner)) & 3;
      nreq = 0;
      for (int k = 0; k < N; k++)
        if (bus.i_hbusreq[k] && k != m_owner) nreq++;
      a = m_park && (bus.i_hbusreq != 0);
      b = !m_park && !bus.i_hbusreq[m_owner];
      c = !m_park && m_beats == MAXB && nreq > 0 && (tr == 0 || tr == 2);
      m_dp = m_owner;
      if (tr >= 2 && m_beats < MAXB) m_beats++;
      nxt    = m_owner;
      m_qexp = 1'b0;
      if (a || b || c) begin
        pick = 1'b0;
        for (int i = 1; i <= N; i++) begin
          m = (m_rr + i) % N;
          if (!pick && bus.i_hbusreq[m] && !(c && !b && m == m_owner)) begin
            pick = 1'b1;
            nxt  = m;
          end
        end
        if (pick) begin
          m_park = 1'b0;
          m_rr   = nxt;
          m_qexp = c && !b;
        end else begin
          nxt    = DEFM;
          m_park = 1'b1;
        end
      end
      if (nxt != m_owner) m_beats = 0;
      m_owner = nxt;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_hgrant", int'(bus.o_hgrant), 1 << m_owner);
      chk("m_hmaster", int'(bus.o_hmaster), m_owner);
      chk("m_hmaster_dp", int'(bus.o_hmaster_dp), m_dp);
      chk("m_qexp", int'(bus.o_quantum_exp), int'(m_qexp));
      chk("m_onehot", int'($onehot(bus.o_hgrant)), 1);
    end
  end

  task automatic drive(input logic r, input logic [3:0] req,
                       input logic [7:0] tr, input logic rdy);
    rst           = r;
    bus.i_hbusreq = req;
    bus.i_htrans  = tr;
    bus.i_hready  = rdy;
    @(negedge clk);
  endtask

  logic [3:0] rot [4];

  initial begin
    checks = 0;
    errors = 0;
`ifdef ARB_HMASTLOCK_EN
    bus.i_hmastlock = '0;
`endif
    rot[0] = 4'b0010;
    rot[1] = 4'b0100;
    rot[2] = 4'b1000;
    rot[3] = 4'b0010;

    // reset
    drive(1, 4'b0000, 8'h00, 1);
    drive(1, 4'b0000, 8'h00, 1);
    chk("rst_hgrant", int'(bus.o_hgrant), 1);
    chk("rst_hmaster", int'(bus.o_hmaster), 0);
    chk("rst_dp", int'(bus.o_hmaster_dp), 0);
    chk("rst_qexp", int'(bus.o_quantum_exp), 0);

    // single requester
    drive(0, 4'b0100, 8'h00, 1);
    chk("single_grant", int'(bus.o_hgrant), 4);
    chk("single_hmaster", int'(bus.o_hmaster), 2);
    drive(0, 4'b0100, 8'h00, 1);
    chk("single_dp", int'(bus.o_hmaster_dp), 2);
    drive(0, 4'b0000, 8'h00, 1);
    chk("single_park", int'(bus.o_hgrant), 1);

    // fairness: 1,2,3 request with NONSEQ every beat
    drive(0, 4'b1110, 8'hAA, 1);
    chk("fair_first", int'(bus.o_hgrant), 8);
    for (int i = 0; i < 4; i++) begin
      repeat (5) drive(0, 4'b1110, 8'hAA, 1);
      chk("fair_rot", int'(bus.o_hgrant), int'(rot[i]));
      chk("fair_qexp", int'(bus.o_quantum_exp), 1);
    end

    // burst protection: owner 1 in SEQ/BUSY, master 3 waiting
    repeat (6) drive(0, 4'b1010, 8'h8C, 1);
    repeat (2) drive(0, 4'b1010, 8'h84, 1);
    repeat (2) drive(0, 4'b1010, 8'h8C, 1);
    chk("burst_hold", int'(bus.o_hgrant), 2);
    drive(0, 4'b1010, 8'h88, 1);
    chk("burst_move", int'(bus.o_hgrant), 8);
    chk("burst_qexp", int'(bus.o_quantum_exp), 1);

    // wait states freeze a pending handover
    drive(0, 4'b1000, 8'h88, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'b0001, 8'h88, 0);
      chk("ws_grant", int'(bus.o_hgrant), 8);
      chk("ws_hmaster", int'(bus.o_hmaster), 3);
      chk("ws_dp", int'(bus.o_hmaster_dp), 3);
    end
    drive(0, 4'b0001, 8'h88, 1);
    chk("ws_handover", int'(bus.o_hgrant), 1);
    chk("ws_qexp", int'(bus.o_quantum_exp), 0);
    drive(0, 4'b0001, 8'h88, 1);
    chk("ws_dp_after", int'(bus.o_hmaster_dp), 0);

    // release and quantum expiry together: single handover, no pulse
    repeat (4) drive(0, 4'b0011, 8'hAA, 1);
    drive(0, 4'b0010, 8'hAA, 1);
    chk("bc_grant", int'(bus.o_hgrant), 2);
    chk("bc_qexp", int'(bus.o_quantum_exp), 0);

    // reset in mid tenure
    repeat (2) drive(0, 4'b0010, 8'hAA, 1);
    drive(1, 4'b0010, 8'hAA, 1);
    chk("midrst_grant", int'(bus.o_hgrant), 1);
    chk("midrst_dp", int'(bus.o_hmaster_dp), 0);
    repeat (2) drive(0, 4'b0000, 8'h00, 1);

    // wrap-around from master 3 to master 0
    drive(0, 4'b1000, 8'h00, 1);
    chk("wrap_own3", int'(bus.o_hgrant), 8);
    drive(0, 4'b0001, 8'h00, 1);
    chk("wrap_to0", int'(bus.o_hmaster), 0);
    repeat (2) drive(0, 4'b0000, 8'h00, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
